axis_capture: RTL and testbench

AXIS_CAPTURE -- requirements
Module: axis_capture

---
 rtl/axis_capture_pkg.sv | 24 ++
 rtl/axis_capture_if.sv | 18 +
 rtl/axis_capture_ram.sv | 28 ++
 rtl/axis_capture.sv | 143 ++++++++++++++
 tb/tb_axis_capture.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_capture_pkg.sv
// Shared definitions for the stream capture block: FSM encoding, default RAM depth
// and sizing helpers used by the top and its storage.
package axis_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEPTH              = 1 << DEFAULT_ADDR_WIDTH;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One stored beat is {tdata, tkeep, tuser, tlast}.
    function automatic int entry_width(input int data_width, input int tuser_width);
        return data_width + data_width / 8 + tuser_width + 1;
    endfunction

endpackage

// File: rtl/axis_capture_if.sv
// AXI-Stream style beat bundle feeding the capture block; the source drives it
// through the master modport, the capture block sinks it through slave.
interface axis_capture_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int TUSER_WIDTH = 256
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_capture_ram.sv
// Simple dual-port capture storage: one write port and a registered read port,
// giving one cycle of read latency.
module capture_ram
    import axis_capture_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:depth_of(ADDR_WIDTH)-1];

    // NOTE: the array and its read register carry no reset so the tools can map them
    // onto block RAM; contents survive a block reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_capture.sv
// Packet-aligned stream capture: arms on start, records whole packets into RAM,
// and stops on a packet limit, RAM exhaustion or an explicit stop.
module axis_capture
    import axis_capture_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic [15:0]                   pkt_limit,
    axis_capture_if.slave                 s_axis,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [AXIS_DATA_WIDTH-1:0]    rd_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  rd_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   rd_tuser,
    output logic                          rd_tlast,
    output logic [ADDR_WIDTH:0]           word_count,
    output logic [15:0]                   pkt_count,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int ENTRY_WIDTH = entry_width(AXIS_DATA_WIDTH, AXIS_TUSER_WIDTH);
    localparam int RAM_DEPTH   = depth_of(ADDR_WIDTH);

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t LAST_SLOT = ptr_t'(RAM_DEPTH - 1);
    localparam ptr_t FULL      = ptr_t'(RAM_DEPTH);

    state_t      state;
    ptr_t        wr_ptr;
    ptr_t        commit_ptr;
    ptr_t        wr_ptr_inc;
    logic [15:0] pkt_count_q;
    logic [15:0] pkt_next;
    logic        overflow_q;
    logic        in_pkt;
    logic        tready_q;
    logic        accept;
    logic        capture_window;
    logic        overflow_hit;
    logic        wr_en;

    logic [ENTRY_WIDTH-1:0] wr_word;
    logic [ENTRY_WIDTH-1:0] rd_word;

    // ARMED with in_pkt low is already on a boundary, so a beat arriving then opens
    // the capture; deferring it would record the tail of that packet.
    always_comb begin
        accept         = s_axis.tvalid && tready_q;
        capture_window = (state == ST_CAPTURE) || ((state == ST_ARMED) && !in_pkt);
        overflow_hit   = accept && capture_window && !stop && !s_axis.tlast
                         && (wr_ptr == LAST_SLOT);
        wr_en          = accept && capture_window && !stop && !overflow_hit;
        wr_ptr_inc     = wr_ptr + ptr_t'(1);
        pkt_next       = (pkt_count_q == 16'hFFFF) ? pkt_count_q : pkt_count_q + 16'd1;
    end

    // NOTE: all state below uses non-blocking assignments so every branch sees the
    // pre-edge values of wr_ptr, commit_ptr and pkt_count_q.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            pkt_count_q <= '0;
            overflow_q  <= 1'b0;
            in_pkt      <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (accept) begin
                in_pkt <= !s_axis.tlast;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        wr_ptr      <= '0;
                        commit_ptr  <= '0;
                        pkt_count_q <= '0;
                        overflow_q  <= 1'b0;
                        state       <= ST_ARMED;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (stop) begin
                        wr_ptr <= commit_ptr;
                        state  <= ST_DONE;
                    end else if (overflow_hit) begin
                        wr_ptr     <= commit_ptr;
                        overflow_q <= 1'b1;
                        state      <= ST_DONE;
                    end else if (capture_window) begin
                        state <= ST_CAPTURE;
                        if (wr_en) begin
                            wr_ptr <= wr_ptr_inc;
                            if (s_axis.tlast) begin
                                commit_ptr  <= wr_ptr_inc;
                                pkt_count_q <= pkt_next;
                                if (((pkt_limit != 16'd0) && (pkt_next == pkt_limit))
                                    || (wr_ptr_inc == FULL)) begin
                                    state <= ST_DONE;
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wr_word = {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast};

    capture_ram #(
        .WIDTH      (ENTRY_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (axis_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    assign {rd_tdata, rd_tkeep, rd_tuser, rd_tlast} = rd_word;

    assign s_axis.tready = tready_q;
    assign word_count    = commit_ptr;
    assign pkt_count     = pkt_count_q;
    assign overflow      = overflow_q;
    assign busy          = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_axis_capture.sv
// Directed bench for axis_capture: a deep instance and an 8-entry instance share
// one stimulus stream, each scenario starting from reset.
module tb_axis_capture;

    localparam int DW   = 32;
    localparam int UW   = 8;
    localparam int KW   = DW / 8;
    localparam int AW_A = 10;
    localparam int AW_B = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   pkt_limit = '0;
    logic [DW-1:0] tdata = '0;
    logic [KW-1:0] tkeep = '0;
    logic [UW-1:0] tuser = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;

    logic [AW_A-1:0] rd_addr_a = '0;
    logic [AW_B-1:0] rd_addr_b = '0;

    logic [DW-1:0] rd_tdata_a, rd_tdata_b;
    logic [KW-1:0] rd_tkeep_a, rd_tkeep_b;
    logic [UW-1:0] rd_tuser_a, rd_tuser_b;
    logic          rd_tlast_a, rd_tlast_b;
    logic [AW_A:0] word_count_a;
    logic [AW_B:0] word_count_b;
    logic [15:0]   pkt_count_a, pkt_count_b;
    logic          busy_a, busy_b, done_a, done_b, overflow_a, overflow_b;

    int n_checks = 0;
    int n_fail   = 0;

    axis_capture_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) if_a ();
    axis_capture_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) if_b ();

    assign if_a.tdata  = tdata;
    assign if_a.tkeep  = tkeep;
    assign if_a.tuser  = tuser;
    assign if_a.tvalid = tvalid;
    assign if_a.tlast  = tlast;
    assign if_b.tdata  = tdata;
    assign if_b.tkeep  = tkeep;
    assign if_b.tuser  = tuser;
    assign if_b.tvalid = tvalid;
    assign if_b.tlast  = tlast;

    axis_capture #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .ADDR_WIDTH(AW_A)) dut_a (
        .axis_aclk (clk),          .axis_reset (rst),
        .start     (start),        .stop       (stop),
        .pkt_limit (pkt_limit),    .s_axis     (if_a.slave),
        .rd_addr   (rd_addr_a),    .rd_tdata   (rd_tdata_a),
        .rd_tkeep  (rd_tkeep_a),   .rd_tuser   (rd_tuser_a),
        .rd_tlast  (rd_tlast_a),   .word_count (word_count_a),
        .pkt_count (pkt_count_a),  .busy       (busy_a),
        .done      (done_a),       .overflow   (overflow_a)
    );

    axis_capture #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .ADDR_WIDTH(AW_B)) dut_b (
        .axis_aclk (clk),          .axis_reset (rst),
        .start     (start),        .stop       (stop),
        .pkt_limit (pkt_limit),    .s_axis     (if_b.slave),
        .rd_addr   (rd_addr_b),    .rd_tdata   (rd_tdata_b),
        .rd_tkeep  (rd_tkeep_b),   .rd_tuser   (rd_tuser_b),
        .rd_tlast  (rd_tlast_b),   .word_count (word_count_b),
        .pkt_count (pkt_count_b),  .busy       (busy_b),
        .done      (done_b),       .overflow   (overflow_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic arm(input logic [15:0] limit);
        pkt_limit = limit;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Last beats carry a partial keep so readout can tell them apart.
    task automatic beat(input logic [DW-1:0] d, input logic last);
        tdata  = d;
        tuser  = d[UW-1:0];
        tkeep  = last ? 4'h3 : 4'hF;
        tlast  = last;
        tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic packet(input logic [DW-1:0] base, input int n);
        for (int b = 0; b < n; b++) begin
            beat(base + DW'(b), b == n - 1);
        end
    endtask

    task automatic read_a(input logic [AW_A-1:0] addr);
        rd_addr_a = addr;
        tick();
    endtask

    task automatic read_b(input logic [AW_B-1:0] addr);
        rd_addr_b = addr;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Reset values, then ready rising once reset is released.
        tick();
        check("rst_tready",   if_a.tready, 1'b0);
        check("rst_busy",     busy_a, 1'b0);
        check("rst_done",     done_a, 1'b0);
        check("rst_wc",       word_count_a, 0);
        check("rst_pc",       pkt_count_a, 0);
        check("rst_ovf",      overflow_a, 1'b0);
        rst = 1'b0;
        tick();
        check("tready_up",    if_a.tready, 1'b1);

        // Packet limit of 2 with three back-to-back 3-beat packets.
        apply_reset();
        arm(16'd2);
        check("armed_busy",   busy_a, 1'b1);
        packet(32'h100, 3);
        packet(32'h200, 3);
        packet(32'h300, 3);
        check("lim_done",     done_a, 1'b1);
        check("lim_busy",     busy_a, 1'b0);
        check("lim_pc",       pkt_count_a, 2);
        check("lim_wc",       word_count_a, 6);
        check("lim_ovf",      overflow_a, 1'b0);
        read_a(10'd5);
        check("lim_rd5_last", rd_tlast_a, 1'b1);
        check("lim_rd5_data", rd_tdata_a, 32'h202);
        check("lim_rd5_keep", rd_tkeep_a, 4'h3);
        read_a(10'd0);
        check("lim_rd0_data", rd_tdata_a, 32'h100);
        check("lim_rd0_user", rd_tuser_a, 8'h00);
        check("lim_rd0_last", rd_tlast_a, 1'b0);

        // Start lands mid-packet: that packet is skipped, the next one is stored.
        apply_reset();
        pkt_limit = 16'd0;
        beat(32'h400, 1'b0);
        start = 1'b1;
        beat(32'h401, 1'b0);
        start = 1'b0;
        beat(32'h402, 1'b0);
        beat(32'h403, 1'b1);
        check("mid_wc_skip",  word_count_a, 0);
        packet(32'h500, 2);
        check("mid_wc",       word_count_a, 2);
        check("mid_pc",       pkt_count_a, 1);
        check("mid_busy",     busy_a, 1'b1);
        read_a(10'd0);
        check("mid_rd0_data", rd_tdata_a, 32'h500);
        read_a(10'd1);
        check("mid_rd1_data", rd_tdata_a, 32'h501);
        check("mid_rd1_last", rd_tlast_a, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ign_pc", pkt_count_a, 1);
        check("restart_ign_wc", word_count_a, 2);

        // Stop on the second beat after one committed packet.
        apply_reset();
        arm(16'd0);
        packet(32'h600, 3);
        beat(32'h700, 1'b0);
        stop = 1'b1;
        beat(32'h701, 1'b0);
        stop = 1'b0;
        check("stop_done",    done_a, 1'b1);
        check("stop_wc",      word_count_a, 3);
        check("stop_pc",      pkt_count_a, 1);
        check("stop_ovf",     overflow_a, 1'b0);
        packet(32'h800, 2);
        check("after_done_wc", word_count_a, 3);
        read_a(10'd2);
        check("stop_rd2_data", rd_tdata_a, 32'h602);

        // Small RAM: second packet cannot fit.
        apply_reset();
        arm(16'd0);
        packet(32'h900, 5);
        packet(32'hA00, 5);
        check("ovf_done",     done_b, 1'b1);
        check("ovf_flag",     overflow_b, 1'b1);
        check("ovf_wc",       word_count_b, 5);
        check("ovf_pc",       pkt_count_b, 1);
        read_b(3'd4);
        check("ovf_rd4_data", rd_tdata_b, 32'h904);
        check("ovf_rd4_last", rd_tlast_b, 1'b1);
        arm(16'd0);
        check("rearm_ovf",    overflow_b, 1'b0);
        check("rearm_wc",     word_count_b, 0);
        check("rearm_busy",   busy_b, 1'b1);

        // Small RAM filled exactly by two packets.
        apply_reset();
        arm(16'd0);
        packet(32'hB00, 4);
        packet(32'hC00, 4);
        check("full_done",    done_b, 1'b1);
        check("full_ovf",     overflow_b, 1'b0);
        check("full_wc",      word_count_b, 8);
        check("full_pc",      pkt_count_b, 2);
        read_b(3'd7);
        check("full_rd7_data", rd_tdata_b, 32'hC03);
        check("full_rd7_last", rd_tlast_b, 1'b1);

        // Reset in the middle of a packet, then a fresh capture.
        apply_reset();
        arm(16'd0);
        packet(32'hD00, 2);
        beat(32'hE00, 1'b0);
        rst = 1'b1;
        #2;
        check("midrst_wc",    word_count_a, 0);
        check("midrst_pc",    pkt_count_a, 0);
        check("midrst_busy",  busy_a, 1'b0);
        check("midrst_tready", if_a.tready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        arm(16'd0);
        packet(32'hF00, 1);
        check("newcap_wc",    word_count_a, 1);
        check("newcap_pc",    pkt_count_a, 1);
        read_a(10'd0);
        check("newcap_rd0",   rd_tdata_a, 32'hF00);
        check("newcap_last",  rd_tlast_a, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
